// File: rtl/execute_mem_brtx.sv
//------------------------------------------------------------------------------
// execute_mem_brtx
//
// Branch record table for the memory execute stage. Each branch prediction
// (direction and target) is recorded under its branch ID. Up to NUM_BC
// resolved branches per cycle are compared against the recorded prediction.
// A wrong prediction produces a registered override with the corrected fetch
// address. Every accepted check produces an updated 2-bit saturating counter
// for the predictor. An entry is released once it has been checked.
//
// Ports
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   i_flush               invalidate every entry, suppress this cycle's checks
//   i_bp_*                prediction record: valid, bid, taken, hit, target
//   i_bc_*                per-channel check: valid, bid, pc, oldpattern,
//                         resolved taken, resolved target (channel k at
//                         [k*W +: W] of each flat bus)
//   o_bco_*               per-channel override: valid, bid, corrected target
//   o_bcu_*               per-channel pattern update: valid, pc, new pattern
//------------------------------------------------------------------------------
module execute_mem_brtx #(
   parameter int BID_W  = 4,
   parameter int IDX_W  = 3,
   parameter int NUM_BC = 2
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    i_flush,
   input  logic                    i_bp_valid,
   input  logic [BID_W-1:0]        i_bp_bid,
   input  logic                    i_bp_taken,
   input  logic                    i_bp_hit,
   input  logic [31:0]             i_bp_target,
   input  logic [NUM_BC-1:0]       i_bc_valid,
   input  logic [NUM_BC*BID_W-1:0] i_bc_bid,
   input  logic [NUM_BC*32-1:0]    i_bc_pc,
   input  logic [NUM_BC*2-1:0]     i_bc_oldpattern,
   input  logic [NUM_BC-1:0]       i_bc_taken,
   input  logic [NUM_BC*32-1:0]    i_bc_target,
   output logic [NUM_BC-1:0]       o_bco_valid,
   output logic [NUM_BC*BID_W-1:0] o_bco_bid,
   output logic [NUM_BC*32-1:0]    o_bco_target,
   output logic [NUM_BC-1:0]       o_bcu_valid,
   output logic [NUM_BC*32-1:0]    o_bcu_pc,
   output logic [NUM_BC*2-1:0]     o_bcu_pattern
);

   localparam int DEPTH = 2 ** IDX_W;

   //---------------------------------------------------------------------------
   // Prediction input register stage
   //---------------------------------------------------------------------------
   logic              r_bp_valid_ir;
   logic [BID_W-1:0]  r_bp_bid_ir;
   logic              r_bp_taken_ir;
   logic [31:0]       r_bp_target_ir;
   logic [IDX_W-1:0]  w_wr_idx;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bp_valid_ir <= 1'b0;
      end else begin
         // A record arriving in a flush cycle belongs to the flushed path.
         r_bp_valid_ir <= i_bp_valid & ~i_flush;
      end
   end

   // A BTB miss records the branch as not-taken.
   always_ff @(posedge clk) begin
      r_bp_bid_ir    <= i_bp_bid;
      r_bp_taken_ir  <= i_bp_taken & i_bp_hit;
      r_bp_target_ir <= i_bp_target;
   end

   assign w_wr_idx = r_bp_bid_ir[IDX_W-1:0];

   //---------------------------------------------------------------------------
   // Table storage
   //---------------------------------------------------------------------------
   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  w_valid_nxt;
   logic [BID_W-1:0]  r_tag    [DEPTH];
   logic [DEPTH-1:0]  r_taken;
   logic [31:0]       r_target [DEPTH];

   // NOTE: the data arrays carry no reset; an entry's fields are only ever
   // read when its valid bit is set, and that bit is reset.
   always_ff @(posedge clk) begin
      if (r_bp_valid_ir) begin
         r_tag[w_wr_idx]    <= r_bp_bid_ir;
         r_taken[w_wr_idx]  <= r_bp_taken_ir;
         r_target[w_wr_idx] <= r_bp_target_ir;
      end
   end

   //---------------------------------------------------------------------------
   // Per-channel lookup, mismatch detection and response formation
   //---------------------------------------------------------------------------
   logic [NUM_BC-1:0]       w_release;
   logic [NUM_BC*IDX_W-1:0] w_bc_idx;
   logic [NUM_BC-1:0]       w_mismatch;
   logic [NUM_BC*32-1:0]    w_corr_target;
   logic [NUM_BC*2-1:0]     w_new_pattern;

   for (genvar k = 0; k < NUM_BC; k++) begin : g_chan
      logic [BID_W-1:0] w_bid;
      logic [IDX_W-1:0] w_idx;
      logic             w_fwd;
      logic             w_view_valid;
      logic [BID_W-1:0] w_view_tag;
      logic             w_view_taken;
      logic [31:0]      w_view_target;
      logic             w_hit;
      logic             w_pred_taken;
      logic             w_taken;
      logic [31:0]      w_target;
      logic [31:0]      w_pc;
      logic [1:0]       w_old;

      assign w_bid    = i_bc_bid[k*BID_W +: BID_W];
      assign w_idx    = w_bid[IDX_W-1:0];
      assign w_taken  = i_bc_taken[k];
      assign w_target = i_bc_target[k*32 +: 32];
      assign w_pc     = i_bc_pc[k*32 +: 32];
      assign w_old    = i_bc_oldpattern[k*2 +: 2];

      // A record still sitting in the input stage is not yet in the table;
      // forward it so a check one cycle after the record already sees it.
      assign w_fwd         = r_bp_valid_ir && (w_wr_idx == w_idx);
      assign w_view_valid  = w_fwd ? 1'b1           : r_valid[w_idx];
      assign w_view_tag    = w_fwd ? r_bp_bid_ir    : r_tag[w_idx];
      assign w_view_taken  = w_fwd ? r_bp_taken_ir  : r_taken[w_idx];
      assign w_view_target = w_fwd ? r_bp_target_ir : r_target[w_idx];

      assign w_hit        = w_view_valid && (w_view_tag == w_bid);
      // An untracked branch was fetched sequentially, i.e. predicted not-taken.
      assign w_pred_taken = w_hit & w_view_taken;

      assign w_mismatch[k] = (w_taken != w_pred_taken) |
                             (w_taken & w_pred_taken & (w_target != w_view_target));

      assign w_release[k]             = i_bc_valid[k] & w_hit;
      assign w_bc_idx[k*IDX_W +: IDX_W] = w_idx;

      // Not-taken resumes after the branch and its delay slot.
      assign w_corr_target[k*32 +: 32] = w_taken ? w_target : (w_pc + 32'd8);

      assign w_new_pattern[k*2 +: 2] =
         w_taken ? ((w_old == 2'd3) ? 2'd3 : (w_old + 2'd1))
                 : ((w_old == 2'd0) ? 2'd0 : (w_old - 2'd1));
   end

   //---------------------------------------------------------------------------
   // Valid-bit update: release, then write (write wins), then flush (wins all)
   //---------------------------------------------------------------------------
   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      w_valid_nxt = r_valid;
      for (int k = 0; k < NUM_BC; k++) begin
         if (w_release[k]) begin
            w_valid_nxt[w_bc_idx[k*IDX_W +: IDX_W]] = 1'b0;
         end
      end
      if (r_bp_valid_ir) begin
         w_valid_nxt[w_wr_idx] = 1'b1;
      end
      if (i_flush) begin
         w_valid_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_valid <= '0;
      end else begin
         r_valid <= w_valid_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Registered outputs; data fields follow the inputs every cycle and are
   // qualified by the valid strobes.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         o_bco_valid   <= '0;
         o_bco_bid     <= '0;
         o_bco_target  <= '0;
         o_bcu_valid   <= '0;
         o_bcu_pc      <= '0;
         o_bcu_pattern <= '0;
      end else begin
         o_bco_valid   <= i_bc_valid & w_mismatch & {NUM_BC{~i_flush}};
         o_bco_bid     <= i_bc_bid;
         o_bco_target  <= w_corr_target;
         o_bcu_valid   <= i_bc_valid & {NUM_BC{~i_flush}};
         o_bcu_pc      <= i_bc_pc;
         o_bcu_pattern <= w_new_pattern;
      end
   end

endmodule

// File: tb/tb_execute_mem_brtx.sv
//------------------------------------------------------------------------------
// tb_execute_mem_brtx
//
// Scoreboard bench for execute_mem_brtx. The driver applies directed and
// random stimulus and, for every check it issues, derives the expected
// response from a record-level reference model and queues it per channel.
// A monitor on the falling edge compares whatever the DUT presents.
//------------------------------------------------------------------------------
module tb_execute_mem_brtx;

   localparam int BID_W  = 4;
   localparam int IDX_W  = 3;
   localparam int NUM_BC = 2;
   localparam int DEPTH  = 8;

   logic                    clk = 1'b0;
   logic                    resetn = 1'b0;
   logic                    flush;
   logic                    bp_valid;
   logic [BID_W-1:0]        bp_bid;
   logic                    bp_taken;
   logic                    bp_hit;
   logic [31:0]             bp_target;
   logic [NUM_BC-1:0]       bc_valid;
   logic [NUM_BC*BID_W-1:0] bc_bid;
   logic [NUM_BC*32-1:0]    bc_pc;
   logic [NUM_BC*2-1:0]     bc_old;
   logic [NUM_BC-1:0]       bc_taken;
   logic [NUM_BC*32-1:0]    bc_target;
   logic [NUM_BC-1:0]       o_bco_valid;
   logic [NUM_BC*BID_W-1:0] o_bco_bid;
   logic [NUM_BC*32-1:0]    o_bco_target;
   logic [NUM_BC-1:0]       o_bcu_valid;
   logic [NUM_BC*32-1:0]    o_bcu_pc;
   logic [NUM_BC*2-1:0]     o_bcu_pattern;

   always #5 clk = ~clk;

   execute_mem_brtx #(.BID_W(BID_W), .IDX_W(IDX_W), .NUM_BC(NUM_BC)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .i_flush         (flush),
      .i_bp_valid      (bp_valid),
      .i_bp_bid        (bp_bid),
      .i_bp_taken      (bp_taken),
      .i_bp_hit        (bp_hit),
      .i_bp_target     (bp_target),
      .i_bc_valid      (bc_valid),
      .i_bc_bid        (bc_bid),
      .i_bc_pc         (bc_pc),
      .i_bc_oldpattern (bc_old),
      .i_bc_taken      (bc_taken),
      .i_bc_target     (bc_target),
      .o_bco_valid     (o_bco_valid),
      .o_bco_bid       (o_bco_bid),
      .o_bco_target    (o_bco_target),
      .o_bcu_valid     (o_bcu_valid),
      .o_bcu_pc        (o_bcu_pc),
      .o_bcu_pattern   (o_bcu_pattern)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Reference model: recorded predictions by index plus the one record that
   // becomes visible in the table one cycle after it is presented.
   //---------------------------------------------------------------------------
   typedef struct {
      bit              v;
      logic [BID_W-1:0] bid;
      bit              taken;
      logic [31:0]     target;
   } rec_t;

   typedef struct {
      int              stamp;
      bit              bco_v;
      logic [BID_W-1:0] bid;
      logic [31:0]     bco_t;
      logic [31:0]     pc;
      logic [1:0]      pat;
   } exp_t;

   rec_t tbl [DEPTH];
   rec_t pend;
   exp_t sb [NUM_BC][$];
   int   edge_cnt = 0;

   always @(posedge clk) edge_cnt++;

   task automatic clear_inputs();
      flush = 0; bp_valid = 0; bp_bid = '0; bp_taken = 0; bp_hit = 0; bp_target = '0;
      bc_valid = '0; bc_bid = '0; bc_pc = '0; bc_old = '0; bc_taken = '0; bc_target = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) tbl[i].v = 0;
      pend.v = 0;
   endtask

   task automatic set_bp(int bid, bit tk, bit hit, logic [31:0] tg);
      bp_valid = 1; bp_bid = BID_W'(bid); bp_taken = tk; bp_hit = hit; bp_target = tg;
   endtask

   task automatic set_bc(int k, int bid, logic [31:0] pc, int old, bit tk, logic [31:0] tg);
      bc_valid[k] = 1'b1;
      bc_bid[k*BID_W +: BID_W] = BID_W'(bid);
      bc_pc[k*32 +: 32] = pc;
      bc_old[k*2 +: 2] = 2'(old);
      bc_taken[k] = tk;
      bc_target[k*32 +: 32] = tg;
   endtask

   // Called at posedge+1 with inputs set: predicts responses, advances the
   // model, crosses one clock edge, returns at posedge+1 with idle inputs.
   task automatic step();
      bit   rel [DEPTH];
      rec_t view;
      exp_t e;
      int   bid, idx, old, p;
      bit   hit, pt, tk, mm;
      logic [31:0] tg, pc;
      for (int i = 0; i < DEPTH; i++) rel[i] = 0;
      for (int k = 0; k < NUM_BC; k++) begin
         if (bc_valid[k]) begin
            bid  = int'(bc_bid[k*BID_W +: BID_W]);
            idx  = bid % DEPTH;
            view = (pend.v && (int'(pend.bid) % DEPTH == idx)) ? pend : tbl[idx];
            hit  = view.v && (int'(view.bid) == bid);
            pt   = hit && view.taken;
            tk   = bc_taken[k];
            tg   = bc_target[k*32 +: 32];
            pc   = bc_pc[k*32 +: 32];
            old  = int'(bc_old[k*2 +: 2]);
            mm   = (tk != pt) || (tk && pt && tg != view.target);
            if (hit) rel[idx] = 1;
            if (!flush) begin
               p = tk ? ((old + 1 > 3) ? 3 : old + 1) : ((old - 1 < 0) ? 0 : old - 1);
               e.stamp = edge_cnt + 1;
               e.bco_v = mm;
               e.bid   = BID_W'(bid);
               e.bco_t = tk ? tg : pc + 32'd8;
               e.pc    = pc;
               e.pat   = 2'(p);
               sb[k].push_back(e);
            end
         end
      end
      for (int i = 0; i < DEPTH; i++) if (rel[i]) tbl[i].v = 0;
      if (pend.v) tbl[int'(pend.bid) % DEPTH] = pend;
      if (flush) for (int i = 0; i < DEPTH; i++) tbl[i].v = 0;
      pend.v      = bp_valid && !flush;
      pend.bid    = bp_bid;
      pend.taken  = bp_taken && bp_hit;
      pend.target = bp_target;
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   //---------------------------------------------------------------------------
   // Monitor
   //---------------------------------------------------------------------------
   exp_t mon_e;
   bit   mon_exp;

   always @(negedge clk) begin
      if (resetn) begin
         for (int k = 0; k < NUM_BC; k++) begin
            mon_exp = (sb[k].size() > 0) && (sb[k][0].stamp == edge_cnt);
            check($sformatf("bcu_valid[%0d]", k), o_bcu_valid[k], mon_exp);
            if (mon_exp) begin
               mon_e = sb[k].pop_front();
               check($sformatf("bco_valid[%0d]", k), o_bco_valid[k], mon_e.bco_v);
               check($sformatf("bcu_pc[%0d]", k), o_bcu_pc[k*32 +: 32], mon_e.pc);
               check($sformatf("bcu_pattern[%0d]", k), o_bcu_pattern[k*2 +: 2], mon_e.pat);
               if (mon_e.bco_v) begin
                  check($sformatf("bco_bid[%0d]", k), o_bco_bid[k*BID_W +: BID_W], mon_e.bid);
                  check($sformatf("bco_target[%0d]", k), o_bco_target[k*32 +: 32], mon_e.bco_t);
               end
            end else begin
               check($sformatf("bco_idle[%0d]", k), o_bco_valid[k], 1'b0);
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   initial begin
      clear_inputs();
      model_reset();
      #1;
      check("reset_bco_valid", o_bco_valid, '0);
      check("reset_bcu_valid", o_bcu_valid, '0);
      check("reset_bco_target", o_bco_target, '0);
      check("reset_bcu_pattern", o_bcu_pattern, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1;
      @(posedge clk);
      #1;

      // Record, check two cycles later from the table, then re-check after release.
      set_bp(5, 1, 1, 32'h1000); step();
      step();
      set_bc(0, 5, 32'h500, 2, 1, 32'h1000); step();
      check("t1_hit_no_override", o_bco_valid[0], 1'b0);
      check("t1_update", o_bcu_valid[0], 1'b1);
      set_bc(0, 5, 32'h500, 2, 1, 32'h1000); step();
      check("t1_recheck_override", o_bco_valid[0], 1'b1);

      // Forwarded not-taken record, resolved taken.
      set_bp(2, 0, 1, 32'h2222); step();
      set_bc(0, 2, 32'h200, 1, 1, 32'h2000); step();
      check("t2_override", o_bco_valid[0], 1'b1);
      check("t2_target", o_bco_target[31:0], 32'h2000);
      check("t2_pattern", o_bcu_pattern[1:0], 2'd2);

      // Wrong target on ch0; tag mismatch on ch1 at the same index.
      set_bp(3, 1, 1, 32'h400); step();
      step();
      set_bc(0, 3, 32'h100, 1, 1, 32'h404);
      set_bc(1, 11, 32'hFFFF_FFFC, 0, 0, 32'h0);
      step();
      check("t3_ch0_override", o_bco_valid[0], 1'b1);
      check("t3_ch0_target", o_bco_target[31:0], 32'h404);
      check("t3_ch1_no_override", o_bco_valid[1], 1'b0);
      check("t3_ch1_pattern", o_bcu_pattern[3:2], 2'd0);

      // Not-taken resolution wraps the fall-through address; saturation at 3.
      set_bp(6, 1, 1, 32'h600); step();
      step();
      set_bc(0, 6, 32'hFFFF_FFFC, 2, 0, 32'h0); step();
      check("t4_wrap_override", o_bco_valid[0], 1'b1);
      check("t4_wrap_target", o_bco_target[31:0], 32'h4);
      set_bc(1, 9, 32'h40, 3, 1, 32'h900); step();
      check("t4_pattern_sat", o_bcu_pattern[3:2], 2'd3);

      // Fill all entries, then flush together with a write and a check.
      for (int i = 0; i < DEPTH; i++) begin
         set_bp(i, 1, 1, 32'(i * 16)); step();
      end
      step();
      flush = 1;
      set_bp(1, 1, 1, 32'h10);
      set_bc(0, 2, 32'h20, 1, 1, 32'h20);
      step();
      check("t5_flush_bcu", o_bcu_valid, '0);
      check("t5_flush_bco", o_bco_valid, '0);
      for (int i = 0; i < DEPTH; i += 2) begin
         set_bc(0, i, 32'h80, 1, 1, 32'(i * 16));
         set_bc(1, i + 1, 32'h90, 1, 1, 32'((i + 1) * 16));
         step();
         check($sformatf("t5_miss_after_flush_%0d", i), o_bco_valid, 2'b11);
      end

      // Asynchronous reset while an override is presented.
      set_bp(4, 1, 1, 32'h44); step();
      step();
      set_bc(0, 7, 32'h70, 0, 1, 32'h700); step();
      check("t6_override_before_reset", o_bco_valid[0], 1'b1);
      @(negedge clk);
      #1;
      resetn = 0;
      #1;
      check("t6_async_bco_valid", o_bco_valid, '0);
      check("t6_async_bcu_valid", o_bcu_valid, '0);
      check("t6_async_bco_bid", o_bco_bid, '0);
      check("t6_async_bco_target", o_bco_target, '0);
      check("t6_async_bcu_pc", o_bcu_pc, '0);
      check("t6_async_bcu_pattern", o_bcu_pattern, '0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      resetn = 1;
      @(posedge clk);
      #1;
      set_bc(0, 4, 32'h40, 1, 1, 32'h44); step();
      check("t6_miss_after_reset", o_bco_valid[0], 1'b1);

      // Randomised traffic over a small target set so hits and mismatches mix.
      for (int n = 0; n < 1500; n++) begin
         flush = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1)
            set_bp(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) != 0), 32'($urandom_range(1, 4)) << 12);
         for (int k = 0; k < NUM_BC; k++) begin
            if ($urandom_range(0, 1) == 1)
               set_bc(k, int'($urandom_range(0, 15)), $urandom,
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(1, 4)) << 12);
         end
         step();
      end

      step();
      step();
      @(negedge clk);
      #1;
      for (int k = 0; k < NUM_BC; k++) begin
         check($sformatf("scoreboard_drained[%0d]", k), 64'(sb[k].size()), 64'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
